regfile_2r2w: RTL and testbench

REGFILE_2R2W -- requirements
Module: regfile_2r2w

---
 rtl/regfile_pkg.sv | 31 +++
 rtl/regfile_clr_fsm.sv | 73 +++++++
 rtl/regfile_2r2w.sv | 111 +++++++++++
 tb/tb_regfile_2r2w.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared definitions for the two-read / two-write register
//                file: default geometry and clear-FSM state encoding.
//  Contents    : c_data_w_default  - default entry width (bits)
//                c_addr_w_default  - default address width (bits)
//                clr_state_t       - clear FSM state (IDLE / CLEAR)
//                last_entry()      - highest entry index for an address width
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int c_data_w_default = 32;
    localparam int c_addr_w_default = 6;

    // Clear sequencer state; one bit is enough for the two states and the
    // encoding is fixed so that downstream logic can decode busy directly.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Index of the final entry for a given address width; this is the value
    // at which the clear sequence terminates instead of wrapping.
    function automatic int last_entry(input int addr_w);
        return (2 ** addr_w) - 1;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_clr_fsm
//  Description : Sequential clear engine for the register file. On a clear
//                request it walks every entry address once, one per clock,
//                and asserts busy for exactly 2**ADDR_W cycles.
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous reset, active low
//                clr_req  - clear request (sampled only while idle)
//                busy     - clear in progress
//                clr_we   - zero the entry at clr_addr this cycle
//                clr_addr - entry currently being cleared
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(last_entry(ADDR_W));

    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_cnt;

    // The counter is only advanced while clearing and is parked at zero
    // when the final entry has been cleared, so it never wraps through
    // the address space on its own.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    // A repeated request while clearing is ignored: no
                    // restart and no extension of the sequence.
                    if (r_cnt == c_last_addr) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs are direct decodes of registered state: glitch-free and
    // aligned with the entry being cleared at the coming edge.
    assign busy     = (r_state == CLEAR);
    assign clr_we   = (r_state == CLEAR);
    assign clr_addr = r_cnt;

endmodule : regfile_clr_fsm
`default_nettype wire

// File: rtl/regfile_2r2w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r2w
//  Description : Register file with two registered read ports and two write
//                ports, plus a sequential clear that zeroes every entry.
//                Port 1 wins when both write ports target the same entry.
//  Ports       : clk            - clock, rising edge
//                rst            - synchronous reset, active low
//                reg_enable     - global enable for reads and writes
//                we0/we1        - write requests
//                waddr0/waddr1  - write addresses
//                wdata0/wdata1  - write data
//                raddr0/raddr1  - read addresses
//                rdata0/rdata1  - registered read data (1-cycle latency)
//                clr_req        - start a sequential clear of all entries
//                busy           - clear in progress, accesses ignored
//  Options     : REGFILE_BYPASS_EN - when defined, a read of an entry being
//                written at the same edge returns the new data (port 1 data
//                if both write ports match); otherwise the old contents.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_2r2w
    import regfile_pkg::*;
#(
    parameter int DATA_W = c_data_w_default,
    parameter int ADDR_W = c_addr_w_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_enable,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clr_req,
    output logic              busy
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_access;
    logic [DATA_W-1:0] w_rd_val0;
    logic [DATA_W-1:0] w_rd_val1;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // A clear request launches the clear at this edge, so any access
    // presented alongside it is dropped as well as those during busy.
    assign w_access = reg_enable & ~w_busy & ~clr_req;

    // Read data selection. With bypass enabled, same-edge writes forward
    // to the read ports; port 1 is checked last so it takes precedence,
    // matching the storage collision rule.
    always_comb begin
        w_rd_val0 = r_mem[raddr0];
        w_rd_val1 = r_mem[raddr1];
`ifdef REGFILE_BYPASS_EN
        if (we0 && (waddr0 == raddr0)) w_rd_val0 = wdata0;
        if (we1 && (waddr1 == raddr0)) w_rd_val0 = wdata1;
        if (we0 && (waddr0 == raddr1)) w_rd_val1 = wdata0;
        if (we1 && (waddr1 == raddr1)) w_rd_val1 = wdata1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_clr_we) begin
            // Clear owns the storage; read registers hold their value.
            r_mem[w_clr_addr] <= '0;
        end else if (w_access) begin
            r_rdata0 <= w_rd_val0;
            r_rdata1 <= w_rd_val1;
            // Port 1 is assigned last so it wins an address collision.
            if (we0) r_mem[waddr0] <= wdata0;
            if (we1) r_mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign busy   = w_busy;

endmodule : regfile_2r2w
`default_nettype wire

// File: tb/tb_regfile_2r2w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_2r2w
//  Description : Self-checking bench for regfile_2r2w. A behavioural model
//                (plain array plus a "cycles of clear left" count) predicts
//                rdata0/rdata1/busy every cycle; directed scenarios add
//                literal expectations, followed by randomized traffic.
//  Options     : REGFILE_BYPASS_EN - must match the RTL build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_2r2w;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk;
    logic          rst;
    logic          reg_enable;
    logic          we0, we1;
    logic [AW-1:0] waddr0, waddr1, raddr0, raddr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata0, rdata1;
    logic          clr_req;
    logic          busy;

    regfile_2r2w #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_enable (reg_enable),
        .we0        (we0),
        .we1        (we1),
        .waddr0     (waddr0),
        .waddr1     (waddr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .raddr0     (raddr0),
        .raddr1     (raddr1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .clr_req    (clr_req),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_r0, m_r1;
    int            m_left;   // clear cycles remaining; nonzero means busy

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (we1 && waddr1 == a)      v = wdata1;
        else if (we0 && waddr0 == a) v = wdata0;
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            m_r0   <= '0;
            m_r1   <= '0;
            m_left <= 0;
        end else if (m_left != 0) begin
            m_mem[DEPTH - m_left] <= '0;
            m_left <= m_left - 1;
        end else if (clr_req) begin
            m_left <= DEPTH;
        end else if (reg_enable) begin
            m_r0 <= exp_read(raddr0);
            m_r1 <= exp_read(raddr1);
            if (we0) m_mem[waddr0] <= wdata0;
            if (we1) m_mem[waddr1] <= wdata1;
        end
    end

    // ------------------------------------------------------------------
    // Single compare process: model checks every cycle plus posted
    // literal expectations from the directed sequence.
    // ------------------------------------------------------------------
    int            errors = 0;
    int            checks = 0;
    logic          chk_en = 1'b0;
    logic          lit_en = 1'b0;
    string         lit_name;
    logic [DW-1:0] lit_act, lit_exp;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (rdata0 !== m_r0) begin
                errors++;
                $display("FAIL rdata0 @%0t: got %h expected %h", $time, rdata0, m_r0);
            end
            checks++;
            if (rdata1 !== m_r1) begin
                errors++;
                $display("FAIL rdata1 @%0t: got %h expected %h", $time, rdata1, m_r1);
            end
            checks++;
            if (busy !== (m_left != 0)) begin
                errors++;
                $display("FAIL busy @%0t: got %b expected %b", $time, busy, (m_left != 0));
            end
        end
        if (lit_en) begin
            checks++;
            if (lit_act !== lit_exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", lit_name, lit_act, lit_exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_en   = 1'b1;
        @(negedge clk);
        #1;
        lit_en   = 1'b0;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    endtask

    task automatic read_all();
        idle();
        reg_enable = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            raddr0 = AW'(a);
            raddr1 = AW'(DEPTH - 1 - a);
            tick();
        end
        reg_enable = 1'b0;
    endtask

    int n_busy;
    logic [DW-1:0] cap;

    initial begin
        rst = 1'b0; reg_enable = 1'b0; idle();
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr0 = '0; raddr1 = '0;

        // Reset held for two edges
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b1;
        lit("reset rdata0", rdata0, 32'h0);
        lit("reset rdata1", rdata1, 32'h0);
        lit("reset busy", {31'b0, busy}, 32'h0);
        read_all();

        // Dual write then dual read
        reg_enable = 1'b1;
        we0 = 1'b1; waddr0 = 6'd5;  wdata0 = 32'hffff0000;
        we1 = 1'b1; waddr1 = 6'd44; wdata1 = 32'hffff0005;
        tick();
        idle();
        raddr0 = 6'd5; raddr1 = 6'd44;
        tick();
        lit("read 5", rdata0, 32'hffff0000);
        lit("read 44", rdata1, 32'hffff0005);

        // Write collision, then write with enable low
        we0 = 1'b1; waddr0 = 6'd63; wdata0 = 32'hffff0006;
        we1 = 1'b1; waddr1 = 6'd63; wdata1 = 32'hffffffff;
        tick();
        idle();
        reg_enable = 1'b0;
        we0 = 1'b1; waddr0 = 6'd30; wdata0 = 32'habcd1234;
        tick();
        idle();
        reg_enable = 1'b1;
        raddr0 = 6'd63; raddr1 = 6'd30;
        tick();
        lit("collision 63", rdata0, 32'hffffffff);
        lit("disabled write 30", rdata1, 32'h0);

        // Clear sequence
        we0 = 1'b1; waddr0 = 6'd5;  wdata0 = 32'h11111111;
        we1 = 1'b1; waddr1 = 6'd15; wdata1 = 32'h22222222;
        tick();
        we1 = 1'b0; waddr0 = 6'd24; wdata0 = 32'h33333333;
        tick();
        idle();
        raddr0 = 6'd24; raddr1 = 6'd15;
        tick();
        lit("pre-clear 24", rdata0, 32'h33333333);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n_busy = 0;
        for (int i = 0; i < 80; i++) begin
            if (busy) n_busy++;
            reg_enable = 1'b1;
            raddr0 = AW'(i);
            raddr1 = AW'(i + 7);
            we0 = (i == 3);
            waddr0 = 6'd15; wdata0 = 32'hdeadbeef;
            clr_req = (i == 10);
            tick();
        end
        idle();
        lit("busy cycles", 32'(n_busy), 32'd64);
        raddr0 = 6'd15; raddr1 = 6'd5;
        tick();
        lit("cleared 15", rdata0, 32'h0);
        read_all();

        // Same-edge write and read
        reg_enable = 1'b1;
        raddr0 = 6'd24; raddr1 = 6'd0;
        we0 = 1'b1; waddr0 = 6'd24; wdata0 = 32'hffff0002;
        tick();
        cap = rdata0;
        idle();
`ifdef REGFILE_BYPASS_EN
        lit("bypass 24", cap, 32'hffff0002);
`else
        lit("no bypass 24", cap, 32'h0);
`endif

        // Reset during clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        lit("busy after abort", {31'b0, busy}, 32'h0);
        reg_enable = 1'b1;
        we0 = 1'b1; waddr0 = 6'd44; wdata0 = 32'h12345678;
        tick();
        idle();
        raddr0 = 6'd44; raddr1 = 6'd44;
        tick();
        lit("post-abort 44", rdata0, 32'h12345678);
        lit("post-abort 44 p1", rdata1, 32'h12345678);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 499) != 0);
            clr_req    = ($urandom_range(0, 199) == 0);
            reg_enable = ($urandom_range(0, 3) != 0);
            we0        = $urandom_range(0, 1);
            we1        = $urandom_range(0, 1);
            waddr0     = AW'($urandom_range(0, DEPTH - 1));
            waddr1     = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, DEPTH - 1));
            wdata0     = $urandom;
            wdata1     = $urandom;
            raddr0     = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, DEPTH - 1));
            raddr1     = ($urandom_range(0, 3) == 0) ? waddr1 : AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        rst = 1'b1;
        read_all();

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_2r2w
`default_nettype wire
